// File: rtl/sprite_pkg.sv
// Shared constants, FSM encoding and limit helpers for the sprite motion block.
package sprite_pkg;

  localparam int unsigned SCREEN_W_DEF = 640;
  localparam int unsigned SCREEN_H_DEF = 480;
  localparam int unsigned SPRITE_W_DEF = 40;
  localparam int unsigned SPRITE_H_DEF = 40;

  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 9;
  localparam int unsigned P_W = 11;
  localparam int unsigned S_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC_X = 2'd1,
    ST_CALC_Y = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // Largest origin X that keeps the sprite fully on screen
  function automatic int unsigned xmax(input int unsigned screen_w, input int unsigned sprite_w);
    return screen_w - sprite_w;
  endfunction

  // Largest origin Y that keeps the sprite fully on screen
  function automatic int unsigned ymax(input int unsigned screen_h, input int unsigned sprite_h);
    return screen_h - sprite_h;
  endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis motion step: advance by speed, clamp to [0, lim] and flip direction on contact.
module sprite_axis_step
  import sprite_pkg::*;
(
  input  logic [P_W-1:0] pos_i,
  input  logic [P_W-1:0] lim_i,
  input  logic [S_W-1:0] speed_i,
  input  logic           dir_i,    // 0 = increasing, 1 = decreasing
  output logic [P_W-1:0] pos_o,
  output logic           dir_o,
  output logic           bounce_o
);

  logic [P_W-1:0] spd;
  logic [P_W-1:0] sum;

  // Clamp exactly onto the edge; the remainder of the step is discarded
  always_comb begin
    spd      = P_W'(speed_i);
    sum      = pos_i + spd;
    pos_o    = pos_i;
    dir_o    = dir_i;
    bounce_o = 1'b0;
    if (speed_i != '0) begin
      if (!dir_i) begin
        if (sum >= lim_i) begin
          pos_o    = lim_i;
          dir_o    = 1'b1;
          bounce_o = 1'b1;
        end else begin
          pos_o = sum;
        end
      end else begin
        if (spd >= pos_i) begin
          pos_o    = '0;
          dir_o    = 1'b0;
          bounce_o = 1'b1;
        end else begin
          pos_o = pos_i - spd;
        end
      end
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite mover: steps X then Y through one shared axis unit during
// vertical blanking and commits both to the renderer-facing registers at once.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned SCREEN_W     = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H     = SCREEN_H_DEF,
  parameter int unsigned SPRITE_W     = SPRITE_W_DEF,
  parameter int unsigned SPRITE_H     = SPRITE_H_DEF,
  parameter int unsigned INIT_X       = 0,
  parameter int unsigned INIT_Y       = 0,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           FRAME_STROBE,
  input  logic           PAUSE,
  input  logic [S_W-1:0] SPEED,
  input  logic           SHOW,
  input  logic           BLINK,
  output logic [X_W-1:0] SPRITE_ORIGIN_OFFSET_X,
  output logic [Y_W-1:0] SPRITE_ORIGIN_OFFSET_Y,
  output logic           VISIBLE,
  output logic [1:0]     BOUNCE
);

  localparam int unsigned XMAX  = xmax(SCREEN_W, SPRITE_W);
  localparam int unsigned YMAX  = ymax(SCREEN_H, SPRITE_H);
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  state_e state_q, state_d;
  logic   ld_x_c, ld_y_c, commit_c;

  logic [X_W-1:0]   x_q, shadow_x_q;
  logic [Y_W-1:0]   y_q, shadow_y_q;
  logic             dir_x_q, dir_y_q;
  logic             bounce_x_q, bounce_y_q;
  logic [1:0]       bounce_q;
  logic [CNT_W-1:0] blink_cnt_q;
  logic             blink_phase_q;

  logic [P_W-1:0] ax_pos, ax_lim, ax_pos_n;
  logic [S_W-1:0] ax_speed;
  logic           ax_dir, ax_dir_n, ax_bounce;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: one cycle per step, strobes outside IDLE are dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (FRAME_STROBE) state_d = ST_CALC_X;
      ST_CALC_X: state_d = ST_CALC_Y;
      ST_CALC_Y: state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    ld_x_c   = 1'b0;
    ld_y_c   = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      ST_CALC_X: ld_x_c   = 1'b1;
      ST_CALC_Y: ld_y_c   = 1'b1;
      ST_COMMIT: commit_c = 1'b1;
      default:   ;
    endcase
  end

  // Share the axis unit between X and Y; pause is just a zero speed
  always_comb begin
    ax_speed = PAUSE ? '0 : SPEED;
    if (ld_y_c) begin
      ax_pos = P_W'(y_q);
      ax_lim = P_W'(YMAX);
      ax_dir = dir_y_q;
    end else begin
      ax_pos = P_W'(x_q);
      ax_lim = P_W'(XMAX);
      ax_dir = dir_x_q;
    end
  end

  sprite_axis_step u_axis (
    .pos_i    (ax_pos),
    .lim_i    (ax_lim),
    .speed_i  (ax_speed),
    .dir_i    (ax_dir),
    .pos_o    (ax_pos_n),
    .dir_o    (ax_dir_n),
    .bounce_o (ax_bounce)
  );

  // Shadow computation, commit and blink bookkeeping
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      x_q           <= X_W'(INIT_X);
      y_q           <= Y_W'(INIT_Y);
      shadow_x_q    <= X_W'(INIT_X);
      shadow_y_q    <= Y_W'(INIT_Y);
      dir_x_q       <= 1'b0;
      dir_y_q       <= 1'b0;
      bounce_x_q    <= 1'b0;
      bounce_y_q    <= 1'b0;
      bounce_q      <= 2'b00;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      bounce_q <= 2'b00;
      if (ld_x_c) begin
        shadow_x_q <= X_W'(ax_pos_n);
        dir_x_q    <= ax_dir_n;
        bounce_x_q <= ax_bounce;
      end
      if (ld_y_c) begin
        shadow_y_q <= Y_W'(ax_pos_n);
        dir_y_q    <= ax_dir_n;
        bounce_y_q <= ax_bounce;
      end
      if (commit_c) begin
        x_q      <= shadow_x_q;
        y_q      <= shadow_y_q;
        bounce_q <= {bounce_y_q, bounce_x_q};
        if (!BLINK) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= 1'b1;
        end else if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign SPRITE_ORIGIN_OFFSET_X = x_q;
  assign SPRITE_ORIGIN_OFFSET_Y = y_q;
  assign BOUNCE                 = bounce_q;
  assign VISIBLE                = SHOW & blink_phase_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: two instances (origin corner with a
// short blink period, far corner) share stimulus; a frame model feeds a scoreboard.
module tb_sprite_motion_ctrl;
  import sprite_pkg::*;

  localparam int XLIM = 600;
  localparam int YLIM = 440;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       FRAME_STROBE = 1'b0;
  logic       PAUSE = 1'b0;
  logic [2:0] SPEED = 3'd0;
  logic       SHOW = 1'b1;
  logic       BLINK = 1'b0;

  logic [9:0] xa, xb;
  logic [8:0] ya, yb;
  logic       va, vb;
  logic [1:0] ba, bb;

  always #5 CLK = ~CLK;

  sprite_motion_ctrl #(.INIT_X(0), .INIT_Y(0), .BLINK_FRAMES(3)) dut_a (
    .CLK(CLK), .RESET(RESET), .FRAME_STROBE(FRAME_STROBE), .PAUSE(PAUSE),
    .SPEED(SPEED), .SHOW(SHOW), .BLINK(BLINK),
    .SPRITE_ORIGIN_OFFSET_X(xa), .SPRITE_ORIGIN_OFFSET_Y(ya),
    .VISIBLE(va), .BOUNCE(ba)
  );

  sprite_motion_ctrl #(.INIT_X(600), .INIT_Y(440)) dut_b (
    .CLK(CLK), .RESET(RESET), .FRAME_STROBE(FRAME_STROBE), .PAUSE(PAUSE),
    .SPEED(SPEED), .SHOW(SHOW), .BLINK(BLINK),
    .SPRITE_ORIGIN_OFFSET_X(xb), .SPRITE_ORIGIN_OFFSET_Y(yb),
    .VISIBLE(vb), .BOUNCE(bb)
  );

  typedef struct {
    int         xa, ya, xb, yb;
    logic [1:0] ba, bb;
    logic       va, vb;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b
  int mx[2], my[2], mcnt[2];
  bit mdx[2], mdy[2], mph[2];
  int mbf[2];
  int ox[2], oy[2];
  logic [1:0] last_ba, last_bb;
  logic       last_va;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx[0] = 0;   my[0] = 0;
    mx[1] = 600; my[1] = 440;
    mbf[0] = 3;  mbf[1] = 30;
    for (int i = 0; i < 2; i++) begin
      mdx[i] = 0; mdy[i] = 0; mcnt[i] = 0; mph[i] = 1;
    end
  endtask

  task automatic axis(input int p, input int m, input int s, input bit d,
                      output int pn, output bit dn, output bit b);
    pn = p; dn = d; b = 0;
    if (s > 0) begin
      if (d == 0) begin
        if (p + s >= m) begin pn = m; dn = 1; b = 1; end
        else pn = p + s;
      end else begin
        if (s >= p) begin pn = 0; dn = 0; b = 1; end
        else pn = p - s;
      end
    end
  endtask

  task automatic model_frame(output exp_t e);
    int s, pn; bit dn, bx, by;
    logic [1:0] bo[2];
    s = PAUSE ? 0 : int'(SPEED);
    for (int i = 0; i < 2; i++) begin
      ox[i] = mx[i]; oy[i] = my[i];
      axis(mx[i], XLIM, s, mdx[i], pn, dn, bx); mx[i] = pn; mdx[i] = dn;
      axis(my[i], YLIM, s, mdy[i], pn, dn, by); my[i] = pn; mdy[i] = dn;
      bo[i] = {by, bx};
      if (!BLINK) begin
        mcnt[i] = 0; mph[i] = 1;
      end else if (mcnt[i] == mbf[i] - 1) begin
        mcnt[i] = 0; mph[i] = !mph[i];
      end else begin
        mcnt[i]++;
      end
    end
    e.xa = mx[0]; e.ya = my[0]; e.ba = bo[0]; e.va = SHOW & mph[0];
    e.xb = mx[1]; e.yb = my[1]; e.bb = bo[1]; e.vb = SHOW & mph[1];
  endtask

  // One frame; strobe stays high for 'hold' cycles starting at the capture edge
  task automatic frame(input int hold);
    exp_t e, got;
    @(negedge CLK);
    FRAME_STROBE = 1'b1;
    model_frame(e);
    sb.push_back(e);
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      if (k == hold) FRAME_STROBE = 1'b0;
      if (k <= 3) begin
        chk("hold_xa", 32'(xa), 32'(ox[0]));
        chk("hold_ya", 32'(ya), 32'(oy[0]));
        chk("hold_xb", 32'(xb), 32'(ox[1]));
        chk("hold_yb", 32'(yb), 32'(oy[1]));
        chk("hold_bounce", 32'({ba, bb}), 32'(0));
      end else begin
        got = sb.pop_front();
        chk("commit_xa", 32'(xa), 32'(got.xa));
        chk("commit_ya", 32'(ya), 32'(got.ya));
        chk("commit_ba", 32'(ba), 32'(got.ba));
        chk("commit_va", 32'(va), 32'(got.va));
        chk("commit_xb", 32'(xb), 32'(got.xb));
        chk("commit_yb", 32'(yb), 32'(got.yb));
        chk("commit_bb", 32'(bb), 32'(got.bb));
        chk("commit_vb", 32'(vb), 32'(got.vb));
        last_ba = ba; last_bb = bb; last_va = va;
      end
    end
    @(negedge CLK);
    chk("bounce_one_cycle", 32'({ba, bb}), 32'(0));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic vis_seq[6];
    vis_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    model_reset();

    // Reset values
    repeat (2) @(negedge CLK);
    chk("rst_xa", 32'(xa), 32'(0));
    chk("rst_ya", 32'(ya), 32'(0));
    chk("rst_va", 32'(va), 32'(1));
    chk("rst_ba", 32'(ba), 32'(0));
    chk("rst_xb", 32'(xb), 32'(600));
    chk("rst_yb", 32'(yb), 32'(440));
    RESET = 1'b0;
    @(negedge CLK);

    // Reset while in CALC_Y aborts the frame
    SPEED = 3'd2;
    FRAME_STROBE = 1'b1;
    @(negedge CLK); FRAME_STROBE = 1'b0;
    @(negedge CLK);
    chk("pre_abort_state", 32'(dut_a.state_q), 32'(ST_CALC_Y));
    RESET = 1'b1;
    #1;
    chk("abort_state", 32'(dut_a.state_q), 32'(ST_IDLE));
    @(negedge CLK); RESET = 1'b0;
    repeat (4) @(negedge CLK);
    chk("abort_xa", 32'(xa), 32'(0));
    chk("abort_ya", 32'(ya), 32'(0));
    chk("abort_ba", 32'(ba), 32'(0));
    chk("abort_xb", 32'(xb), 32'(600));
    model_reset();

    // Far corner, both heading outward: clamp with double bounce, then retreat
    SPEED = 3'd7;
    frame(1);
    chk("corner_bb", 32'(last_bb), 32'(2'b11));
    chk("corner_xb", 32'(xb), 32'(600));
    chk("corner_yb", 32'(yb), 32'(440));
    frame(1);
    chk("retreat_xb", 32'(xb), 32'(593));
    chk("retreat_yb", 32'(yb), 32'(433));
    chk("retreat_xa", 32'(xa), 32'(14));

    // Walk to (100,100)
    SPEED = 3'd2;
    for (int i = 0; i < 43; i++) frame(1);
    chk("walk_xa", 32'(xa), 32'(100));
    chk("walk_ya", 32'(ya), 32'(100));

    // Pause freezes position
    PAUSE = 1'b1;
    for (int i = 0; i < 5; i++) frame(1);
    chk("pause_xa", 32'(xa), 32'(100));
    chk("pause_ya", 32'(ya), 32'(100));
    PAUSE = 1'b0;

    // Strobe held four cycles gives one step
    frame(4);
    chk("long_strobe_xa", 32'(xa), 32'(102));
    for (int i = 0; i < 49; i++) frame(1);
    chk("walk2_xa", 32'(xa), 32'(200));
    chk("walk2_ya", 32'(ya), 32'(200));

    // Approach the right edge, then overshoot clamps with an X-only bounce
    for (int i = 0; i < 199; i++) frame(1);
    chk("near_edge_xa", 32'(xa), 32'(598));
    SPEED = 3'd5;
    frame(1);
    chk("edge_xa", 32'(xa), 32'(600));
    chk("edge_ba", 32'(last_ba), 32'(2'b01));
    frame(1);
    chk("back_xa", 32'(xa), 32'(595));

    // Blink with period 3
    SPEED = 3'd0;
    BLINK = 1'b1;
    for (int i = 0; i < 6; i++) begin
      frame(1);
      chk("blink_seq", 32'(last_va), 32'(vis_seq[i]));
    end
    BLINK = 1'b0;
    frame(1);
    chk("blink_off_va", 32'(va), 32'(1));

    // SHOW acts without waiting for a frame
    @(negedge CLK); SHOW = 1'b0;
    @(negedge CLK);
    chk("show_off_va", 32'(va), 32'(0));
    chk("show_off_vb", 32'(vb), 32'(0));
    SHOW = 1'b1;
    @(negedge CLK);
    chk("show_on_va", 32'(va), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
- Upstream stage of each sprite renderer.
- Once per frame, during vertical blanking, it advances a sprite's origin by a programmable speed and bounces the sprite off the screen edges.
- It drives the renderer's origin-offset and visibility inputs: SPRITE_ORIGIN_OFFSET_X[9:0], SPRITE_ORIGIN_OFFSET_Y[8:0] and VISIBLE.
- Outputs are double-buffered, so they never change during active video.

Parameters:
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- SPRITE_W, 40, sprite width (matches renderer).
- SPRITE_H, 40, sprite height (matches renderer).
- INIT_X, 0, origin X after reset; must be <= SCREEN_W-SPRITE_W.
- INIT_Y, 0, origin Y after reset; must be <= SCREEN_H-SPRITE_H.
- BLINK_FRAMES, 30, frames per visibility toggle in blink mode; must be >= 1.

Ports:
- CLK  in  1  pixel clock.
- RESET  in  1  asynchronous, active-high reset.
- FRAME_STROBE  in  1  one-cycle pulse at start of vertical blanking, from the VGA timing generator.
- PAUSE  in  1  level; 1 freezes position (strobes still counted for blink).
- SPEED  in  3  pixels per frame per axis; 0 = stationary.
- SHOW  in  1  level; 0 forces VISIBLE low.
- BLINK  in  1  level; 1 enables blink mode.
- SPRITE_ORIGIN_OFFSET_X  out  10  committed origin X.
- SPRITE_ORIGIN_OFFSET_Y  out  9  committed origin Y.
- VISIBLE  out  1  committed visibility.
- BOUNCE  out  2  one-cycle pulse at commit; bit0 = X edge hit, bit1 = Y edge hit.

Behaviour:
- Reset is asynchronous, active-high. While RESET is high:
  - state = IDLE; X = INIT_X, Y = INIT_Y; shadow registers equal outputs.
  - dir_x = dir_y = + (increasing).
  - blink_cnt = 0, blink_phase = 1; VISIBLE = SHOW (combinational from the committed phase register, which resets to 1); BOUNCE = 0.
- Reset asserted mid-sequence aborts the sequence immediately; no partial commit occurs.
- Limits: XMAX = SCREEN_W-SPRITE_W (600), YMAX = SCREEN_H-SPRITE_H (440). All position arithmetic uses 11-bit unsigned intermediates; nothing wraps.
- FSM, one cycle per state: IDLE -> CALC_X -> CALC_Y -> COMMIT -> IDLE.
  - IDLE: leaves only when FRAME_STROBE = 1 at a clock edge (edge E0).
  - CALC_X (edge E1): compute shadow_x and dir_x and latch bounce_x, using the axis rule.
  - CALC_Y (edge E2): same for Y.
  - COMMIT (edge E3): load outputs from the shadow registers, drive BOUNCE for exactly one cycle, update the blink state. Latency is 3 cycles from strobe to output change.
- FRAME_STROBE while not in IDLE is ignored; no queuing.
- Axis rule, for position p, limit M, speed s, direction d:
  - d = +: if p+s >= M then p' = M, d' = -, bounce = 1 (bounce only if s > 0); else p' = p+s.
  - d = -: if s >= p then p' = 0, d' = +, bounce = (s > 0); else p' = p-s.
  - The position clamps exactly to the edge; no overshoot or reflection of the remainder.
  - s = 0: p, d unchanged, bounce = 0.
  - PAUSE = 1 (sampled at E1 and E2) is treated as s = 0 for that axis.
- Both axes may bounce in the same frame, giving BOUNCE = 2'b11.
- Blink, evaluated at COMMIT:
  - BLINK = 0: blink_cnt = 0, blink_phase = 1.
  - BLINK = 1: blink_cnt increments; when it reaches BLINK_FRAMES-1 it clears and blink_phase toggles.
  - VISIBLE = SHOW & blink_phase. SHOW acts immediately; it does not wait for a frame.
- SPEED is sampled at E1 and E2 only; changes mid-frame take effect at the next strobe.

Decomposition:
- Shared package sprite_pkg:
  - SCREEN_W, SCREEN_H, SPRITE_W, SPRITE_H defaults.
  - Derived XMAX/YMAX functions.
  - FSM state encoding (IDLE=0, CALC_X=1, CALC_Y=2, COMMIT=3).
  - Width constants: X_W = 10, Y_W = 9.
- One sub-module, sprite_axis_step: the combinational axis rule (p, M, s, d -> p', d', bounce), 11-bit internal width.
  - Instantiated once and muxed between the X and Y operands by state, so only one adder/comparator is needed.

Test Plan:
- Reset with INIT_X=0, INIT_Y=0 -> X=0, Y=0, VISIBLE=SHOW, BOUNCE=0. Assert RESET at CALC_Y -> outputs remain at init; state = IDLE.
- SPEED=2, one strobe from (0,0) -> X=2, Y=2 exactly 3 cycles after the strobe edge, unchanged on cycles 1-2; 100 strobes -> (200,200).
- X=598, dir +, SPEED=5 -> X=600, BOUNCE[0] pulses for one cycle; next strobe -> X=595.
- Start X=600, Y=440, both dir +, SPEED=7 -> clamp to (600,440), BOUNCE=2'b11 for one cycle; next strobe -> (593,433).
- PAUSE=1 for 5 strobes at (100,100) -> position unchanged, BOUNCE=0. Strobe held high 4 consecutive cycles -> exactly one step taken.
- BLINK=1, BLINK_FRAMES=3, SHOW=1 -> VISIBLE = 1,1,0,0,0,1 at successive commits. SHOW=0 mid-frame -> VISIBLE low next cycle.
